// File: rtl/sprite_pixel_reader.sv
// ---------------------------------------------------------------------------
// sprite_pixel_reader
//
// Places one 24x32 sprite on screen and returns the sprite pixel for each VGA
// draw coordinate. It sits between the VGA timing counters and the colour
// mapper. Colour code TRANSP is transparent. Position changes are held in
// pending registers and only take effect at frame start, so the sprite never
// tears. The block also counts the opaque sprite pixels drawn in each frame.
//
// Ports:
//   Clk, Reset_n       clock, asynchronous active-low reset
//   sprite_rgb         bitmap [row][col], bits [8:0] are the colour code
//   draw_x, draw_y     current draw coordinate
//   pix_valid_in       draw_x/draw_y are a visible pixel this cycle
//   frame_start        one-cycle pulse at the start of vertical blank
//   pos_x_next/pos_y_next/flip_next, pos_update
//                      requested position and mirror, plus capture strobe
//   pix_valid_out      pix_valid_in delayed by two cycles
//   pix_hit, pix_color opaque-sprite flag and colour (colour is 0 on a miss)
//   pos_ack            pulses in the cycle a pending position goes live
//   hit_count          opaque-pixel count of the last completed frame
// ---------------------------------------------------------------------------
module sprite_pixel_reader #(
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 24,
  parameter int COORD_W = 10,
  parameter int TRANSP  = 391
) (
  input  logic                                 Clk,
  input  logic                                 Reset_n,
  input  logic [0:SPR_H-1][0:SPR_W-1][9:0]     sprite_rgb,
  input  logic [COORD_W-1:0]                   draw_x,
  input  logic [COORD_W-1:0]                   draw_y,
  input  logic                                 pix_valid_in,
  input  logic                                 frame_start,
  input  logic [COORD_W-1:0]                   pos_x_next,
  input  logic [COORD_W-1:0]                   pos_y_next,
  input  logic                                 flip_next,
  input  logic                                 pos_update,
  output logic                                 pix_valid_out,
  output logic                                 pix_hit,
  output logic [8:0]                           pix_color,
  output logic                                 pos_ack,
  output logic [15:0]                          hit_count
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  // Pending and active sprite position
  logic [COORD_W-1:0] pend_x_q, pend_y_q, act_x_q, act_y_q;
  logic               pend_flip_q, pend_vld_q, act_flip_q, pos_ack_q;

  // Stage 1 registers
  logic               s1_valid_q, s1_in_box_q;
  logic [ROW_W-1:0]   s1_row_q;
  logic [COL_W-1:0]   s1_col_q;

  // Stage 2 (output) registers
  logic               s2_valid_q, s2_hit_q;
  logic [8:0]         s2_color_q;

  // Hit counters
  logic [15:0]        hit_acc_q, hit_count_q;

  // Stage 1 next-state
  logic [COORD_W:0]   dx_full, dy_full;
  logic               in_box_d;
  logic [COL_W-1:0]   dx_col, col_d;
  logic [ROW_W-1:0]   row_d;

  // Stage 2 next-state and counter next-state
  logic [8:0]         color_code;
  logic               hit_d;
  logic [16:0]        acc_sum;
  logic [15:0]        acc_sat_d;

  // The extra top bit of each difference is the borrow, so a draw coordinate
  // left of or above the sprite is rejected instead of wrapping around.
  assign dx_full  = {1'b0, draw_x} - {1'b0, act_x_q};
  assign dy_full  = {1'b0, draw_y} - {1'b0, act_y_q};
  assign in_box_d = pix_valid_in
                    && !dx_full[COORD_W] && !dy_full[COORD_W]
                    && (dx_full[COORD_W-1:0] < COORD_W'(SPR_W))
                    && (dy_full[COORD_W-1:0] < COORD_W'(SPR_H));
  assign dx_col   = dx_full[COL_W-1:0];

  // Row/column are zeroed outside the box so stage 2 never indexes past the
  // bitmap.
  assign col_d = !in_box_d   ? '0 :
                 act_flip_q  ? COL_W'(SPR_W - 1) - dx_col : dx_col;
  assign row_d = in_box_d ? dy_full[ROW_W-1:0] : '0;

  assign color_code = sprite_rgb[s1_row_q][s1_col_q][8:0];
  assign hit_d      = s1_in_box_q && (color_code != 9'(TRANSP));

  // The pixel currently on the output counts toward this frame, even when
  // frame_start arrives in the same cycle.
  assign acc_sum   = {1'b0, hit_acc_q} + 17'(s2_hit_q);
  assign acc_sat_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];

  // Position shadowing: the last pos_update before frame_start wins, and an
  // update in the frame_start cycle itself goes live straight away.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_flip_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_flip_q  <= 1'b0;
      pos_ack_q   <= 1'b0;
    end else begin
      pos_ack_q <= 1'b0;
      if (pos_update) begin
        pend_x_q    <= pos_x_next;
        pend_y_q    <= pos_y_next;
        pend_flip_q <= flip_next;
        pend_vld_q  <= 1'b1;
      end
      if (frame_start && (pend_vld_q || pos_update)) begin
        act_x_q    <= pos_update ? pos_x_next : pend_x_q;
        act_y_q    <= pos_update ? pos_y_next : pend_y_q;
        act_flip_q <= pos_update ? flip_next  : pend_flip_q;
        pend_vld_q <= 1'b0;
        pos_ack_q  <= 1'b1;
      end
    end
  end

  // Two-stage pixel pipeline with a fixed latency and no stalls
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_in_box_q <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_hit_q    <= 1'b0;
      s2_color_q  <= '0;
    end else begin
      s1_valid_q  <= pix_valid_in;
      s1_in_box_q <= in_box_d;
      s1_row_q    <= row_d;
      s1_col_q    <= col_d;
      s2_valid_q  <= s1_valid_q;
      s2_hit_q    <= hit_d;
      s2_color_q  <= hit_d ? color_code : 9'd0;
    end
  end

  // Per-frame opaque-pixel counting, saturating at all ones
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_acc_q   <= '0;
      hit_count_q <= '0;
    end else if (frame_start) begin
      hit_count_q <= acc_sat_d;
      hit_acc_q   <= '0;
    end else begin
      hit_acc_q   <= acc_sat_d;
    end
  end

  assign pix_valid_out = s2_valid_q;
  assign pix_hit       = s2_hit_q;
  assign pix_color     = s2_color_q;
  assign pos_ack       = pos_ack_q;
  assign hit_count     = hit_count_q;

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// ---------------------------------------------------------------------------
// tb_sprite_pixel_reader
//
// Directed-vector bench for sprite_pixel_reader. A behavioural model computes
// the expected output for every draw coordinate from the sprite position
// rules. Hand-computed literal checks pin the model to known bitmap values.
// ---------------------------------------------------------------------------
module tb_sprite_pixel_reader;

  logic                      Clk = 1'b0;
  logic                      Reset_n;
  logic [0:23][0:31][9:0]    bitmap;
  logic [9:0]                drawX, drawY, posXNext, posYNext;
  logic                      pixValidIn, frameStart, posUpdate, flipNext;
  logic                      pixValidOut, pixHit, posAck;
  logic [8:0]                pixColor;
  logic [15:0]               hitCount;

  int vectorCount = 0;
  int failCount   = 0;

  // Behavioural model state
  int mActX, mActY, mPendX, mPendY;
  bit mActFlip, mPendFlip, mPendVld;
  bit s1V, s1Hit, outV, outHit, mAck, ackNow, newHit;
  int s1Color, outColor, newColor, mAcc, mCount;

  sprite_pixel_reader dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .sprite_rgb   (bitmap),
    .draw_x       (drawX),
    .draw_y       (drawY),
    .pix_valid_in (pixValidIn),
    .frame_start  (frameStart),
    .pos_x_next   (posXNext),
    .pos_y_next   (posYNext),
    .flip_next    (flipNext),
    .pos_update   (posUpdate),
    .pix_valid_out(pixValidOut),
    .pix_hit      (pixHit),
    .pix_color    (pixColor),
    .pos_ack      (posAck),
    .hit_count    (hitCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected pixel from plain screen geometry: is the point inside the
  // sprite rectangle, which bitmap cell is it, and is that cell opaque.
  function automatic void lookup(input int x, input int y, input bit v,
                                 output bit hit, output int color);
    int relX, relY, col, c;
    relX  = x - mActX;
    relY  = y - mActY;
    hit   = 1'b0;
    color = 0;
    if (v && relX >= 0 && relX < 32 && relY >= 0 && relY < 24) begin
      col = mActFlip ? 31 - relX : relX;
      c   = int'(bitmap[relY][col]) % 512;
      if (c != 391) begin
        hit   = 1'b1;
        color = c;
      end
    end
  endfunction

  // Model: advances once per clock, mirrors what the outputs must show
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mActX = 0; mActY = 0; mActFlip = 0;
      mPendX = 0; mPendY = 0; mPendFlip = 0; mPendVld = 0;
      s1V = 0; s1Hit = 0; s1Color = 0;
      outV = 0; outHit = 0; outColor = 0;
      mAck = 0; mAcc = 0; mCount = 0;
    end else begin
      if (frameStart) begin
        mCount = (mAcc + int'(outHit) > 65535) ? 65535 : mAcc + int'(outHit);
        mAcc   = 0;
      end else if (outHit) begin
        mAcc = (mAcc + 1 > 65535) ? 65535 : mAcc + 1;
      end
      outV = s1V; outHit = s1Hit; outColor = s1Color;
      lookup(int'(drawX), int'(drawY), pixValidIn, newHit, newColor);
      s1V = pixValidIn; s1Hit = newHit; s1Color = newColor;
      ackNow = frameStart && (mPendVld || posUpdate);
      mAck   = ackNow;
      if (posUpdate) begin
        mPendX = int'(posXNext); mPendY = int'(posYNext);
        mPendFlip = flipNext; mPendVld = 1;
      end
      if (ackNow) begin
        mActX = mPendX; mActY = mPendY; mActFlip = mPendFlip; mPendVld = 0;
      end
    end
  end

  // Compare process: every cycle out of reset, all outputs against the model
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      checkOutput("cyc_pix_valid_out", 32'(pixValidOut), 32'(outV));
      checkOutput("cyc_pix_hit",       32'(pixHit),      32'(outHit));
      checkOutput("cyc_pix_color",     32'(pixColor),    32'(outColor));
      checkOutput("cyc_pos_ack",       32'(posAck),      32'(mAck));
      checkOutput("cyc_hit_count",     32'(hitCount),    32'(mCount));
    end
  end

  task automatic applyStimulus(input int x, input int y, input bit v,
                               input bit fs, input bit upd, input int px,
                               input int py, input bit fl);
    @(negedge Clk);
    drawX = 10'(x); drawY = 10'(y); pixValidIn = v;
    frameStart = fs; posUpdate = upd;
    posXNext = 10'(px); posYNext = 10'(py); flipNext = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pixel(input int x, input int y);
    applyStimulus(x, y, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic moveTo(input int px, input int py, input bit fl);
    applyStimulus(0, 0, 0, 0, 1, px, py, fl);
  endtask

  task automatic frameStartPulse();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
  endtask

  task automatic expectPixel(input string name, input int x, input int y,
                             input bit hit, input int color);
    pixel(x, y);
    idle(2);
    checkOutput({name, "_valid"}, 32'(pixValidOut), 32'd1);
    checkOutput({name, "_hit"},   32'(pixHit),      32'(hit));
    checkOutput({name, "_color"}, 32'(pixColor),    32'(color));
  endtask

  initial begin
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++)
        bitmap[r][c] = 10'(r * 32 + c);
    // Base pattern holds one transparent cell at [12][7]; add known cells.
    bitmap[2][5]  = 10'd430;
    bitmap[2][7]  = 10'd700;
    bitmap[3][31] = 10'd123;
    bitmap[3][0]  = 10'd391;
    bitmap[5][5]  = 10'd903;
    bitmap[0][0]  = 10'd0;
    drawX = 0; drawY = 0; pixValidIn = 0; frameStart = 0; posUpdate = 0;
    posXNext = 0; posYNext = 0; flipNext = 0;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checkOutput("rst_pix_valid_out", 32'(pixValidOut), 32'd0);
    checkOutput("rst_pix_hit",       32'(pixHit),      32'd0);
    checkOutput("rst_pix_color",     32'(pixColor),    32'd0);
    checkOutput("rst_pos_ack",       32'(posAck),      32'd0);
    checkOutput("rst_hit_count",     32'(hitCount),    32'd0);

    // Default position (0,0)
    expectPixel("home_5_2", 5, 2, 1, 430);
    expectPixel("home_40_2", 40, 2, 0, 0);

    // Shadowed move to (100,50)
    moveTo(100, 50, 0);
    expectPixel("before_fs_5_2", 5, 2, 1, 430);
    frameStartPulse();
    checkOutput("move_ack_pulse", 32'(posAck), 32'd1);
    idle(1);
    checkOutput("move_ack_clear", 32'(posAck), 32'd0);
    expectPixel("moved_107_52", 107, 52, 1, 188);
    expectPixel("moved_99_52", 99, 52, 0, 0);
    expectPixel("moved_132_50", 132, 50, 0, 0);
    expectPixel("moved_131_50", 131, 50, 1, 31);

    // Last update wins
    moveTo(10, 10, 0);
    moveTo(20, 20, 0);
    frameStartPulse();
    expectPixel("last_wins_25_22", 25, 22, 1, 430);
    expectPixel("last_wins_15_12", 15, 12, 0, 0);

    // Update and frame start in the same cycle
    applyStimulus(0, 0, 0, 1, 1, 30, 30, 0);
    idle(1);
    checkOutput("same_cycle_ack", 32'(posAck), 32'd1);
    expectPixel("same_cycle_35_32", 35, 32, 1, 430);

    // Horizontal mirror at (0,0)
    moveTo(0, 0, 1);
    frameStartPulse();
    expectPixel("flip_0_3", 0, 3, 1, 123);
    expectPixel("flip_31_3", 31, 3, 0, 0);
    expectPixel("flip_0_2", 0, 2, 1, 95);
    expectPixel("flip_31_2", 31, 2, 1, 64);

    // No wrap-around at the right edge
    moveTo(1020, 0, 0);
    frameStartPulse();
    expectPixel("nowrap_3_0", 3, 0, 0, 0);
    expectPixel("edge_1023_0", 1023, 0, 1, 3);

    // Full sweep: 768 sprite cells minus 3 transparent ones
    moveTo(0, 0, 0);
    frameStartPulse();
    for (int y = 0; y < 26; y++)
      for (int x = 0; x < 40; x++)
        pixel(x, y);
    idle(3);
    frameStartPulse();
    checkOutput("sweep_hit_count", 32'(hitCount), 32'd765);

    // Saturation
    for (int i = 0; i < 65600; i++) pixel(0, 0);
    idle(3);
    frameStartPulse();
    checkOutput("sat_hit_count", 32'(hitCount), 32'hFFFF);

    // Reset mid-frame with pixels in flight and a pending move
    moveTo(200, 100, 0);
    pixel(5, 2);
    pixel(6, 2);
    pixel(7, 2);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("midrst_pix_valid_out", 32'(pixValidOut), 32'd0);
    checkOutput("midrst_pix_hit",       32'(pixHit),      32'd0);
    checkOutput("midrst_pix_color",     32'(pixColor),    32'd0);
    checkOutput("midrst_pos_ack",       32'(posAck),      32'd0);
    checkOutput("midrst_hit_count",     32'(hitCount),    32'd0);
    idle(1);
    Reset_n = 1'b1;
    frameStartPulse();
    checkOutput("post_rst_no_ack", 32'(posAck), 32'd0);
    expectPixel("post_rst_5_2", 5, 2, 1, 430);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_reader.md
Name: sprite_pixel_reader

Overview:
- Consumer side of the 24x32 sprite colour-map modules (digit and tile bitmaps): places one sprite on screen and returns its pixel for each VGA draw coordinate.
- Sits between the VGA timing counters and the colour mapper. Colour code 391 is treated as transparent.
- Position updates are shadowed and applied only at frame start, so the sprite never tears.
- Also counts opaque sprite pixels drawn per frame, for collision and debug use.

Parameters:
- SPR_W, 32, sprite width in pixels (column index range).
- SPR_H, 24, sprite height in pixels (row index range).
- COORD_W, 10, width of screen coordinates.
- TRANSP, 391, colour code treated as transparent.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- sprite_rgb  in  10 x [0:SPR_H-1][0:SPR_W-1]  bitmap array, indexed [row][col]; only bits [8:0] are used, bit 9 is ignored.
- draw_x  in  COORD_W  current pixel column.
- draw_y  in  COORD_W  current pixel row.
- pix_valid_in  in  1  draw_x/draw_y are a visible pixel this cycle.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pos_x_next  in  COORD_W  requested sprite left edge.
- pos_y_next  in  COORD_W  requested sprite top edge.
- flip_next  in  1  requested horizontal mirror.
- pos_update  in  1  one-cycle strobe; captures pos_x_next, pos_y_next and flip_next into the pending registers.
- pix_valid_out  out  1  pix_valid_in delayed by 2 cycles.
- pix_hit  out  1  the output pixel is an opaque sprite pixel.
- pix_color  out  9  sprite colour when pix_hit=1, else 0.
- pos_ack  out  1  one-cycle pulse in the cycle the pending position becomes active.
- hit_count  out  16  opaque-pixel count of the last completed frame.

Behaviour:
- Registers:
  - pending: pend_x, pend_y, pend_flip, pend_vld.
  - active: act_x, act_y, act_flip.
  - hit_acc: running count.
  - pipeline registers for stage 1 and stage 2.
- Reset (async, Reset_n=0): all registers cleared to 0. Outputs pix_valid_out=0, pix_hit=0, pix_color=0, pos_ack=0, hit_count=0. Pipeline contents are discarded on reset mid-frame.
- pos_update=1: pending <= next inputs, pend_vld <= 1. With several updates before a frame_start, the last one wins.
- frame_start=1:
  - If pend_vld=1 (or pos_update=1 in the same cycle): active <= pending (same-cycle next inputs take priority), pend_vld <= 0, pos_ack=1 in the next cycle.
  - hit_count <= hit_acc, including any hit reported in that same cycle.
  - hit_acc <= 0.
- Stage 1, registered, in cycle N+1:
  - dx = draw_x - act_x; dy = draw_y - act_y, both computed at COORD_W+1 bits with a borrow.
  - in_box = no borrow on either, dx < SPR_W, dy < SPR_H, and pix_valid_in=1.
  - col = act_flip ? SPR_W-1-dx : dx.
  - Active values are sampled when the pixel enters stage 1. Pixels already in flight keep their old position.
- Stage 2, registered, in cycle N+2:
  - c = sprite_rgb[dy][col][8:0].
  - pix_hit = in_box && (c != TRANSP).
  - pix_color = pix_hit ? c : 0.
  - pix_valid_out = stage-1 valid.
  - Total latency is exactly 2 cycles, with no stalls.
- Sprite clipping:
  - A sprite partially off the right or bottom of the screen is clipped naturally.
  - Coordinates are not wrapped: act_x = 1020 with draw_x = 3 gives no hit.
- Hit counting: hit_acc increments by 1 on each cycle with pix_hit=1 and saturates at 16'hFFFF.
- If frame_start and pix_valid_in arrive in the same cycle, the pixel uses the old active position. frame_start is normally only asserted in blanking.

Test Plan:
- Reset, then run a frame with no pos_update -> sprite at (0,0).
  - draw (5,2) over a 430 pixel -> pix_hit=1, pix_color=430, 2 cycles later.
  - draw (40,2) -> pix_hit=0, pix_color=0.
- pos_update (100,50,0), then frame_start -> pos_ack pulses once.
  - draw (107,52) returns bitmap[2][7].
  - draw (99,52) and (132,50) -> no hit.
  - Any pixel before frame_start still uses the old position.
- Two pos_updates, (10,10) then (20,20), then frame_start -> active = (20,20).
  - pos_update and frame_start in the same cycle with (30,30) -> active = (30,30) immediately.
- flip_next=1 at (0,0): draw (0,r) returns bitmap[r][31]; draw (31,r) returns bitmap[r][0].
- Sweep a full frame over a bitmap with K non-391 pixels -> hit_count = K after the next frame_start.
  - Forced 70000 hits -> hit_count = 16'hFFFF.
- Assert Reset_n low mid-frame with pixels in flight -> all outputs 0 at once; the pending update is lost and the sprite returns to (0,0).
